// File: rtl/eth_payload_writer.sv
// eth_payload_writer
//   Loads one PAYLOAD_BYTES-wide payload word into the eth_tx2 frame buffer,
//   one byte per write strobe starting at BASE_ADDR. It then pulses
//   eth_start and follows tx_busy until the transmitter has finished.
//   The payload comes from an internal sequence counter that launches every
//   PERIOD enabled cycles (SRC_EXT=0), or from a valid/ready input (SRC_EXT=1).
//   Every state change is qualified by clk_en.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_en              clock enable; nothing advances while 0
//   enable              0 blocks new launches; a frame in flight still completes
//   clr_flags           synchronous clear of overrun/timeout (needs clk_en)
//   payload_i/_valid    external payload and its valid (SRC_EXT=1)
//   payload_ready       high in IDLE with enable=1 and tx_busy=0 (SRC_EXT=1 only)
//   tx_busy             transmit busy from eth_tx2
//   eth_w_addr/_data/_en  frame buffer write port
//   eth_start           one-enabled-cycle frame start pulse
//   seq_o               last payload word launched
//   overrun, timeout    sticky error flags
module eth_payload_writer #(
    parameter int                PAYLOAD_BYTES = 4,
    parameter int                ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 8'h38,
    parameter bit                BIG_ENDIAN    = 1'b1,
    parameter int                PERIOD        = 2**21,
    parameter int                BUSY_TO       = 1024,
    parameter bit                SRC_EXT       = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       enable,
    input  logic                       clr_flags,
    input  logic [8*PAYLOAD_BYTES-1:0] payload_i,
    input  logic                       payload_valid,
    output logic                       payload_ready,
    input  logic                       tx_busy,
    output logic [ADDR_W-1:0]          eth_w_addr,
    output logic [7:0]                 eth_w_data,
    output logic                       eth_w_en,
    output logic                       eth_start,
    output logic [8*PAYLOAD_BYTES-1:0] seq_o,
    output logic                       overrun,
    output logic                       timeout
);

    localparam int PW  = 8 * PAYLOAD_BYTES;
    localparam int PCW = $clog2(PERIOD);
    localparam int BCW = $clog2(BUSY_TO + 1);
    localparam int IW  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WR,
        S_STB,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t          state_reg;
    logic [PCW-1:0]  period_cnt_reg;
    logic [BCW-1:0]  busy_cnt_reg;
    logic [IW-1:0]   byte_idx_reg;
    logic [PW-1:0]   word_reg;
    logic [PW-1:0]   cap_reg;
    logic            pending_reg;

    logic            in_idle;
    logic            period_wrap;
    logic            int_req;
    logic            int_launch;
    logic            ext_launch;
    logic            launch;
    logic [PW-1:0]   word_next;
    logic [7:0]      word_bytes [PAYLOAD_BYTES];

    assign in_idle     = (state_reg == S_IDLE);
    assign period_wrap = (period_cnt_reg == PCW'(PERIOD - 1));

    // A period wrap only counts as a request while launches are enabled.
    assign int_req     = !SRC_EXT && clk_en && period_wrap && enable;

    assign payload_ready = SRC_EXT && in_idle && enable && !tx_busy;

    // A request that arrived while the transmitter was busy stays pending
    // until tx_busy drops, as long as we are still idle.
    assign int_launch = !SRC_EXT && clk_en && in_idle && enable && !tx_busy
                        && (int_req || pending_reg);
    assign ext_launch = clk_en && payload_valid && payload_ready;
    assign launch     = int_launch || ext_launch;

    // In internal mode seq_o always holds the last sequence value, so the
    // next word is simply seq_o + 1 (wrapping naturally at 2^PW).
    assign word_next = SRC_EXT ? cap_reg : (seq_o + PW'(1));

    // Byte lane i of the word, already ordered by buffer address.
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_bytes
        localparam int LANE = BIG_ENDIAN ? (PAYLOAD_BYTES - 1 - gi) : gi;
        assign word_bytes[gi] = word_reg[8*LANE +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            period_cnt_reg <= '0;
            busy_cnt_reg   <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            cap_reg        <= '0;
            pending_reg    <= 1'b0;
            eth_w_addr     <= '0;
            eth_w_data     <= '0;
            eth_w_en       <= 1'b0;
            eth_start      <= 1'b0;
            seq_o          <= '0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;
        end else if (clk_en) begin
            period_cnt_reg <= period_wrap ? '0 : period_cnt_reg + PCW'(1);

            // Clear first so that a set event in the same cycle wins.
            if (clr_flags) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (int_req && !in_idle) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        cap_reg     <= payload_i;
                        pending_reg <= 1'b0;
                        state_reg   <= S_LATCH;
                    end else if (int_req) begin
                        pending_reg <= 1'b1;
                    end
                end
                S_LATCH: begin
                    word_reg     <= word_next;
                    seq_o        <= word_next;
                    byte_idx_reg <= '0;
                    state_reg    <= S_WR;
                end
                S_WR: begin
                    eth_w_addr <= BASE_ADDR + ADDR_W'(byte_idx_reg);
                    eth_w_data <= word_bytes[byte_idx_reg];
                    eth_w_en   <= 1'b1;
                    state_reg  <= S_STB;
                end
                S_STB: begin
                    eth_w_en <= 1'b0;
                    if (byte_idx_reg == IW'(PAYLOAD_BYTES - 1)) begin
                        eth_start <= 1'b1;
                        state_reg <= S_START;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + IW'(1);
                        state_reg    <= S_WR;
                    end
                end
                S_START: begin
                    eth_start    <= 1'b0;
                    busy_cnt_reg <= '0;
                    state_reg    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state_reg <= S_WAIT_LO;
                    end else if (busy_cnt_reg == BCW'(BUSY_TO - 1)) begin
                        timeout   <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg + BCW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_payload_writer.sv
// tb_eth_payload_writer
//   Two instances share the clock, reset, clk_en, enable and clr_flags inputs:
//     u0: internal counter source, big endian, PERIOD=16, BUSY_TO=1024
//     u1: external handshake source, little endian, BUSY_TO=20
//   A frame-level reference model predicts every output on every cycle. A
//   responder plays the role of eth_tx2 on tx_busy. Directed phases pin known
//   literal results.
module tb_eth_payload_writer;

    localparam int PB       = 4;
    localparam int PW       = 8 * PB;
    localparam int PERIOD_A = 16;
    localparam int BTO_A    = 1024;
    localparam int BTO_B    = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          enable = 1'b0;
    logic          clr_flags = 1'b0;
    logic [1:0]    tx_busy;
    logic [PW-1:0] payload_i = '0;
    logic          payload_valid = 1'b0;

    logic          ready   [2];
    logic [7:0]    w_addr  [2];
    logic [7:0]    w_data  [2];
    logic          w_en    [2];
    logic          start   [2];
    logic [PW-1:0] seq_o   [2];
    logic          overrun [2];
    logic          timeout [2];

    eth_payload_writer #(
        .PAYLOAD_BYTES(PB), .ADDR_W(8), .BASE_ADDR(8'h38), .BIG_ENDIAN(1'b1),
        .PERIOD(PERIOD_A), .BUSY_TO(BTO_A), .SRC_EXT(1'b0)
    ) dut_int (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .enable(enable),
        .clr_flags(clr_flags), .payload_i(32'h0), .payload_valid(1'b0),
        .payload_ready(ready[0]), .tx_busy(tx_busy[0]),
        .eth_w_addr(w_addr[0]), .eth_w_data(w_data[0]), .eth_w_en(w_en[0]),
        .eth_start(start[0]), .seq_o(seq_o[0]),
        .overrun(overrun[0]), .timeout(timeout[0])
    );

    eth_payload_writer #(
        .PAYLOAD_BYTES(PB), .ADDR_W(8), .BASE_ADDR(8'h38), .BIG_ENDIAN(1'b0),
        .PERIOD(2**21), .BUSY_TO(BTO_B), .SRC_EXT(1'b1)
    ) dut_ext (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .enable(enable),
        .clr_flags(clr_flags), .payload_i(payload_i), .payload_valid(payload_valid),
        .payload_ready(ready[1]), .tx_busy(tx_busy[1]),
        .eth_w_addr(w_addr[1]), .eth_w_data(w_data[1]), .eth_w_en(w_en[1]),
        .eth_start(start[1]), .seq_o(seq_o[1]),
        .overrun(overrun[1]), .timeout(timeout[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 frame being written (k = enabled edges since launch),
    //        2 waiting for tx_busy to rise, 3 waiting for tx_busy to fall
    int            m_phase [2];
    int            m_k     [2];
    int            m_whi   [2];
    logic [PW-1:0] m_word  [2];
    logic [PW-1:0] m_seqo  [2];
    logic [7:0]    m_addr  [2];
    logic [7:0]    m_data  [2];
    bit            m_wen   [2];
    bit            m_start [2];
    bit            m_over  [2];
    bit            m_to    [2];
    int            m_pcnt;
    bit            m_pend;
    logic [PW-1:0] m_seq;
    int            en_edges = 0;

    function automatic logic [7:0] byte_of(input logic [PW-1:0] w, input int i, input bit be);
        int lane;
        lane = be ? (PB - 1 - i) : i;
        return 8'((w >> (8 * lane)) & 32'hFF);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0; m_k[u] = 0; m_whi[u] = 0; m_word[u] = '0; m_seqo[u] = '0;
            m_addr[u] = '0; m_data[u] = '0; m_wen[u] = 0; m_start[u] = 0;
            m_over[u] = 0; m_to[u] = 0;
        end
        m_pcnt = 0; m_pend = 0; m_seq = '0;
    endtask

    task automatic model_step();
        bit req;
        en_edges++;
        req = 0;
        if (m_pcnt == PERIOD_A - 1) begin
            m_pcnt = 0;
            req = enable;
        end else begin
            m_pcnt++;
        end
        for (int u = 0; u < 2; u++) begin
            int  pre;
            bit  launch;
            bit  to_set;
            bit  ov_set;
            pre = m_phase[u];
            launch = 0; to_set = 0; ov_set = 0;
            m_wen[u] = 0;
            m_start[u] = 0;
            case (pre)
                0: begin
                    if (u == 0) begin
                        if ((req || m_pend) && enable && !tx_busy[0]) begin
                            launch = 1;
                            m_pend = 0;
                        end else if (req) begin
                            m_pend = 1;
                        end
                    end else if (payload_valid && enable && !tx_busy[1]) begin
                        launch = 1;
                    end
                    if (launch) begin
                        if (u == 0) begin
                            m_seq = m_seq + 1;
                            m_word[u] = m_seq;
                        end else begin
                            m_word[u] = payload_i;
                        end
                        m_phase[u] = 1;
                        m_k[u] = 1;
                    end
                end
                1: begin
                    m_k[u]++;
                    if (m_k[u] == 2) m_seqo[u] = m_word[u];
                    if (m_k[u] >= 3 && m_k[u] <= 2*PB + 1 && (m_k[u] % 2) == 1) begin
                        int i;
                        i = (m_k[u] - 3) / 2;
                        m_wen[u]  = 1;
                        m_addr[u] = 8'(8'h38 + i);
                        m_data[u] = byte_of(m_word[u], i, u == 0);
                    end
                    if (m_k[u] == 2*PB + 2) m_start[u] = 1;
                    if (m_k[u] == 2*PB + 3) begin
                        m_phase[u] = 2;
                        m_whi[u] = 0;
                    end
                end
                2: begin
                    if (tx_busy[u]) begin
                        m_phase[u] = 3;
                    end else begin
                        m_whi[u]++;
                        if (m_whi[u] == ((u == 0) ? BTO_A : BTO_B)) begin
                            to_set = 1;
                            m_phase[u] = 0;
                        end
                    end
                end
                default: begin
                    if (!tx_busy[u]) m_phase[u] = 0;
                end
            endcase
            if (u == 0 && pre != 0 && req) ov_set = 1;
            if (clr_flags) begin
                m_over[u] = 0;
                m_to[u] = 0;
            end
            if (ov_set) m_over[u] = 1;
            if (to_set) m_to[u] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (clk_en) model_step();
        end
    end

    // ---------------- compare + monitor ----------------
    logic [15:0] wlog0[$];
    logic [15:0] wlog1[$];
    int  a_start_cnt = 0;
    int  a_start_edge = 0;
    int  a_busy_writes = 0;
    bit  ovr_phase = 0;
    int  wen_run = 0, start_run = 0, max_wen_run = 0, max_start_run = 0;

    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                bit exp_ready;
                exp_ready = (u == 1) && (m_phase[1] == 0) && enable && !tx_busy[1];
                chk($sformatf("u%0d_w_en", u),    w_en[u],    m_wen[u]);
                chk($sformatf("u%0d_w_addr", u),  w_addr[u],  m_addr[u]);
                chk($sformatf("u%0d_w_data", u),  w_data[u],  m_data[u]);
                chk($sformatf("u%0d_start", u),   start[u],   m_start[u]);
                chk($sformatf("u%0d_seq_o", u),   seq_o[u],   m_seqo[u]);
                chk($sformatf("u%0d_overrun", u), overrun[u], m_over[u]);
                chk($sformatf("u%0d_timeout", u), timeout[u], m_to[u]);
                chk($sformatf("u%0d_ready", u),   ready[u],   exp_ready);
            end
            if (clk_en) begin
                if (w_en[0]) wlog0.push_back({w_addr[0], w_data[0]});
                if (w_en[1]) wlog1.push_back({w_addr[1], w_data[1]});
                if (ovr_phase && tx_busy[0] && w_en[0]) a_busy_writes++;
                for (int u = 0; u < 2; u++) begin
                    if (start[u]) $display("frame u%0d start seq_o=%08h", u, seq_o[u]);
                end
                if (start[0]) begin
                    a_start_cnt++;
                    a_start_edge = en_edges;
                end
                wen_run   = w_en[0]  ? wen_run + 1   : 0;
                start_run = start[0] ? start_run + 1 : 0;
                if (wen_run > max_wen_run) max_wen_run = wen_run;
                if (start_run > max_start_run) max_start_run = start_run;
            end
        end
    end

    // ---------------- tx_busy responder (eth_tx2 stand-in) ----------------
    // mode 0: busy after 0..3 cycles for 3..12 cycles; 1: never busy; 2: busy 100 cycles
    int mode [2];
    bit glitch_en = 0;

    initial begin
        int dly [2];
        int hold [2];
        bit prev [2];
        tx_busy = '0;
        mode[0] = 0; mode[1] = 0;
        for (int u = 0; u < 2; u++) begin
            dly[u] = -1; hold[u] = 0; prev[u] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int u = 0; u < 2; u++) begin
                if (!rst_n) begin
                    tx_busy[u] = 1'b0; dly[u] = -1; hold[u] = 0; prev[u] = 0;
                end else begin
                    if (start[u] && !prev[u] && mode[u] != 1) begin
                        dly[u]  = $urandom_range(0, 3);
                        hold[u] = (mode[u] == 2) ? 100 : $urandom_range(3, 12);
                    end
                    prev[u] = start[u];
                    if (dly[u] > 0) begin
                        dly[u]--;
                    end else if (dly[u] == 0) begin
                        if (hold[u] > 0) begin
                            tx_busy[u] = 1'b1;
                            hold[u]--;
                        end else begin
                            tx_busy[u] = 1'b0;
                            dly[u] = -1;
                        end
                    end else if (glitch_en && mode[u] == 0 && $urandom_range(0, 40) == 0) begin
                        tx_busy[u] = 1'b1;
                        dly[u] = 0;
                        hold[u] = 1;
                    end else begin
                        tx_busy[u] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        enable = 1'b0;
        tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        wait_neg();
        chk("clr_overrun", overrun[0], 1'b0);
        chk("clr_timeout", timeout[0], 1'b0);
        tick();
        enable = 1'b1;
    endtask

    initial begin
        int s0;
        int t0;
        int n0;

        repeat (3) tick();
        chk("rst_w_en",  w_en[0],    1'b0);
        chk("rst_start", start[0],   1'b0);
        chk("rst_addr",  w_addr[0],  8'h00);
        chk("rst_seq",   seq_o[0],   32'h0);
        chk("rst_ready", ready[1],   1'b0);

        // First frames: u0 from the counter, u1 from payload_i.
        rst_n = 1'b1;
        clk_en = 1'b1;
        enable = 1'b1;
        payload_i = 32'hA1B2C3D4;
        payload_valid = 1'b1;
        for (int c = 0; c < 100 && wlog1.size() < 4; c++) wait_neg();
        chk("ext_frame_seen", wlog1.size() >= 4, 1'b1);
        chk("ext_ready_busy", ready[1], 1'b0);
        chk("ext_wr0", wlog1[0], 16'h38D4);
        chk("ext_wr1", wlog1[1], 16'h39C3);
        chk("ext_wr2", wlog1[2], 16'h3AB2);
        chk("ext_wr3", wlog1[3], 16'h3BA1);
        chk("ext_seq", seq_o[1], 32'hA1B2C3D4);
        payload_valid = 1'b0;
        for (int c = 0; c < 100 && a_start_cnt < 1; c++) wait_neg();
        chk("int_frame_seen", wlog0.size() >= 4, 1'b1);
        chk("int_wr0", wlog0[0], 16'h3800);
        chk("int_wr1", wlog0[1], 16'h3900);
        chk("int_wr2", wlog0[2], 16'h3A00);
        chk("int_wr3", wlog0[3], 16'h3B01);
        chk("int_seq", seq_o[0], 32'h1);

        // Timeout: tx_busy never rises after a start.
        mode[0] = 1;
        s0 = a_start_cnt;
        for (int c = 0; c < 200 && a_start_cnt <= s0; c++) wait_neg();
        t0 = a_start_edge;
        for (int c = 0; c < 1200 && !timeout[0]; c++) wait_neg();
        chk("timeout_set", timeout[0], 1'b1);
        chk("timeout_latency", en_edges - t0, 1025);
        mode[0] = 0;
        pulse_clr();
        n0 = wlog0.size();
        for (int c = 0; c < 100 && wlog0.size() < n0 + 4; c++) wait_neg();
        chk("after_timeout_frame", wlog0.size() >= n0 + 4, 1'b1);

        // Overrun: transmitter stays busy for 100 cycles.
        mode[0] = 2;
        a_busy_writes = 0;
        ovr_phase = 1'b1;
        s0 = a_start_cnt;
        for (int c = 0; c < 200 && a_start_cnt <= s0; c++) wait_neg();
        repeat (110) wait_neg();
        chk("overrun_set", overrun[0], 1'b1);
        chk("no_writes_busy", a_busy_writes, 0);
        ovr_phase = 1'b0;
        mode[0] = 0;
        pulse_clr();

        // clk_en toggling every cycle.
        max_wen_run = 0;
        max_start_run = 0;
        for (int c = 0; c < 300; c++) begin
            clk_en = ~clk_en;
            tick();
        end
        clk_en = 1'b1;
        chk("wen_width", max_wen_run, 1);
        chk("start_width", max_start_run, 1);
        for (int i = 0; i < wlog0.size(); i++) begin
            chk($sformatf("addr_order_%0d", i), wlog0[i][15:8], 8'(8'h38 + (i % 4)));
        end

        // Randomized traffic.
        glitch_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            clk_en        = ($urandom_range(0, 3) != 0);
            enable        = ($urandom_range(0, 9) != 0);
            clr_flags     = ($urandom_range(0, 24) == 0);
            payload_valid = $urandom_range(0, 1);
            payload_i     = $urandom;
            tick();
        end

        // Reset in the middle of a write strobe.
        glitch_en = 1'b0;
        clr_flags = 1'b0;
        payload_valid = 1'b0;
        clk_en = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 200 && !w_en[0]; c++) wait_neg();
        chk("stb_reached", w_en[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_w_en",    w_en[0],    1'b0);
        chk("midrst_addr",    w_addr[0],  8'h00);
        chk("midrst_data",    w_data[0],  8'h00);
        chk("midrst_start",   start[0],   1'b0);
        chk("midrst_seq",     seq_o[0],   32'h0);
        chk("midrst_overrun", overrun[0], 1'b0);
        chk("midrst_timeout", timeout[0], 1'b0);
        chk("midrst_seq_ext", seq_o[1],   32'h0);
        tick();
        tick();
        wlog0.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 100 && wlog0.size() < 4; c++) wait_neg();
        chk("postrst_frame_seen", wlog0.size() >= 4, 1'b1);
        chk("postrst_seq", seq_o[0], 32'h1);
        chk("postrst_wr0", wlog0[0], 16'h3800);
        chk("postrst_wr3", wlog0[3], 16'h3B01);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
